if_fetch: RTL and testbench

// Instruction fetch stage of the RV32I core: owns the PC, issues word fetches on the

---
 rtl/if_fetch.sv | 178 +++++++++++++++++
 tb/tb_if_fetch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage of the RV32I core.
// Owns the PC and issues single-word fetches on a req/gnt/rvalid instruction bus
// with at most one request outstanding. Fetched words go to decode through
// a registered output. A one-entry skid buffer absorbs a response that arrives
// while decode is stalling. A jump from execute redirects the PC and squashes
// any in-flight fetch.
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   jump_i          redirect pulse from execute
//   jump_addr_i     redirect target (low two bits ignored)
//   hold_i          decode stall: output register frozen
//   ibus_req_o      fetch request valid
//   ibus_addr_o     fetch address
//   ibus_gnt_i      request accepted
//   ibus_rvalid_i   read data valid
//   ibus_rdata_i    read data
//   inst_o          instruction to decode (NOP when invalid)
//   inst_addr_o     address of inst_o
//   inst_valid_o    inst_o holds a live instruction
module if_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_i,
  output logic              ibus_req_o,
  output logic [ADDR_W-1:0] ibus_addr_o,
  input  logic              ibus_gnt_i,
  input  logic              ibus_rvalid_i,
  input  logic [DATA_W-1:0] ibus_rdata_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_valid_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-3){1'b0}}, 3'd4};

  state_e            state_r, state_s;
  logic [ADDR_W-1:0] pc_r, pc_s;
  logic [ADDR_W-1:0] req_addr_r, req_addr_s;
  logic              kill_r, kill_s;
  logic [DATA_W-1:0] skid_inst_r, skid_inst_s;
  logic [ADDR_W-1:0] skid_addr_r, skid_addr_s;
  logic [DATA_W-1:0] out_inst_s;
  logic [ADDR_W-1:0] out_addr_s;
  logic              out_valid_s;

  // Request is gated by reset so nothing is issued while the core is held in reset.
  assign ibus_req_o  = (state_r == S_REQ) & ~rst;
  assign ibus_addr_o = pc_r;

  // Next-state, PC, skid and output-register selection.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    req_addr_s  = req_addr_r;
    kill_s      = kill_r;
    skid_inst_s = skid_inst_r;
    skid_addr_s = skid_addr_r;
    out_inst_s  = inst_o;
    out_addr_s  = inst_addr_o;
    out_valid_s = inst_valid_o;
    if (jump_i) begin
      // Redirect wins over everything, including a decode stall.
      pc_s        = {jump_addr_i[ADDR_W-1:2], 2'b00};
      out_inst_s  = NOP_INST;
      out_valid_s = 1'b0;
      case (state_r)
        S_REQ: begin
          if (ibus_gnt_i) begin
            // The old-PC fetch is already on the bus; its response must be discarded.
            state_s    = S_WAIT;
            req_addr_s = pc_r;
            kill_s     = 1'b1;
          end else begin
            state_s = S_REQ;
          end
        end
        S_WAIT: begin
          if (ibus_rvalid_i) begin
            state_s = S_REQ;
            kill_s  = 1'b0;
          end else begin
            kill_s = 1'b1;
          end
        end
        S_FULL:  state_s = S_REQ;
        default: state_s = S_REQ;
      endcase
    end else begin
      // Without a stall the output register drains to a bubble unless reloaded below.
      if (!hold_i) begin
        out_inst_s  = NOP_INST;
        out_valid_s = 1'b0;
      end else begin
        out_valid_s = inst_valid_o;
      end
      case (state_r)
        S_REQ: begin
          if (ibus_gnt_i) begin
            state_s    = S_WAIT;
            req_addr_s = pc_r;
          end else begin
            state_s = S_REQ;
          end
        end
        S_WAIT: begin
          if (!ibus_rvalid_i) begin
            state_s = S_WAIT;
          end else if (kill_r) begin
            kill_s  = 1'b0;
            state_s = S_REQ;
          end else if (!hold_i) begin
            out_inst_s  = ibus_rdata_i;
            out_addr_s  = req_addr_r;
            out_valid_s = 1'b1;
            pc_s        = req_addr_r + PC_STEP;
            state_s     = S_REQ;
          end else begin
            skid_inst_s = ibus_rdata_i;
            skid_addr_s = req_addr_r;
            pc_s        = req_addr_r + PC_STEP;
            state_s     = S_FULL;
          end
        end
        S_FULL: begin
          // No new request until the skid entry has moved into the output register.
          if (!hold_i) begin
            out_inst_s  = skid_inst_r;
            out_addr_s  = skid_addr_r;
            out_valid_s = 1'b1;
            state_s     = S_REQ;
          end else begin
            state_s = S_FULL;
          end
        end
        default: state_s = S_REQ;
      endcase
    end
  end

  // State, PC, skid and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_REQ;
      pc_r         <= RESET_PC;
      req_addr_r   <= RESET_PC;
      kill_r       <= 1'b0;
      skid_inst_r  <= NOP_INST;
      skid_addr_r  <= {ADDR_W{1'b0}};
      inst_o       <= NOP_INST;
      inst_addr_o  <= {ADDR_W{1'b0}};
      inst_valid_o <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      req_addr_r   <= req_addr_s;
      kill_r       <= kill_s;
      skid_inst_r  <= skid_inst_s;
      skid_addr_r  <= skid_addr_s;
      inst_o       <= out_inst_s;
      inst_addr_o  <= out_addr_s;
      inst_valid_o <= out_valid_s;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed self-checking bench for if_fetch.
// A small bus responder inside the cycle task grants requests on demand and
// returns memory data one cycle later. Memory content is addr ^ 32'h0010_0093.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        hold_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  int n_pass;
  int n_total;

  logic        auto_gnt;
  logic        rv_en;
  logic        pend;
  logic [31:0] pend_addr;

  if_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .jump_i       (jump_i),
    .jump_addr_i  (jump_addr_i),
    .hold_i       (hold_i),
    .ibus_req_o   (ibus_req_o),
    .ibus_addr_o  (ibus_addr_o),
    .ibus_gnt_i   (ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i),
    .ibus_rdata_i (ibus_rdata_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h0010_0093;
  endfunction

  // One clock cycle: drive bus responses, advance to the edge, settle #1 after it.
  task automatic cycle();
    logic        g;
    logic        r;
    logic [31:0] a;
    #1;
    g = auto_gnt & ibus_req_o;
    r = pend & rv_en;
    a = ibus_addr_o;
    ibus_gnt_i    = g;
    ibus_rvalid_i = r;
    ibus_rdata_i  = r ? mem(pend_addr) : 32'hDEAD_BEEF;
    @(posedge clk);
    if (r) pend = 1'b0;
    if (g) begin
      pend      = 1'b1;
      pend_addr = a;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; jump_i = 1'b0; jump_addr_i = 32'h0; hold_i = 1'b0;
    auto_gnt = 1'b1; rv_en = 1'b1;
    cycle();
    cycle();
    pend = 1'b0;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; jump_i = 1'b0; jump_addr_i = 32'h0; hold_i = 1'b0;
    auto_gnt = 1'b1; rv_en = 1'b1; pend = 1'b0;
    cycle();
    cycle();
    n_total++; if (ibus_req_o !== 1'b0) $display("FAIL rst_req: got %0b exp 0", ibus_req_o); else n_pass++;
    n_total++; if (inst_valid_o !== 1'b0) $display("FAIL rst_valid: got %0b exp 0", inst_valid_o); else n_pass++;
    n_total++; if (inst_o !== NOP) $display("FAIL rst_inst: got %h exp %h", inst_o, NOP); else n_pass++;
    n_total++; if (inst_addr_o !== 32'h0) $display("FAIL rst_addr: got %h exp 0", inst_addr_o); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0) $display("FAIL rst_release_req: got %0b/%h exp 1/00000000", ibus_req_o, ibus_addr_o); else n_pass++;
  endtask

  task automatic test_first_fetch();
    do_reset();
    cycle();
    n_total++; if (inst_valid_o !== 1'b0 || ibus_req_o !== 1'b0) $display("FAIL t1_wait: valid %0b req %0b exp 0/0", inst_valid_o, ibus_req_o); else n_pass++;
    cycle();
    n_total++; if (inst_valid_o !== 1'b1) $display("FAIL t1_valid: got %0b exp 1", inst_valid_o); else n_pass++;
    n_total++; if (inst_o !== 32'h0010_0093) $display("FAIL t1_inst: got %h exp 00100093", inst_o); else n_pass++;
    n_total++; if (inst_addr_o !== 32'h0) $display("FAIL t1_addr: got %h exp 0", inst_addr_o); else n_pass++;
  endtask

  task automatic test_stream();
    logic        exp_v;
    logic [31:0] exp_a;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle();
      exp_v = (i % 2 == 1);
      n_total++; if (inst_valid_o !== exp_v) $display("FAIL stream_valid[%0d]: got %0b exp %0b", i, inst_valid_o, exp_v); else n_pass++;
      if (exp_v) begin
        exp_a = 32'((i / 2) * 4);
        n_total++;
        if (inst_addr_o !== exp_a || inst_o !== mem(exp_a))
          $display("FAIL stream_data[%0d]: got %h@%h exp %h@%h", i, inst_o, inst_addr_o, mem(exp_a), exp_a);
        else n_pass++;
      end
    end
  endtask

  task automatic test_hold_skid();
    do_reset();
    for (int i = 0; i < 4; i++) cycle();
    hold_i = 1'b1;
    cycle();   // grant for 0x8 while decode stalls
    cycle();   // response for 0x8 goes to the skid
    n_total++; if (inst_o !== mem(32'h4) || inst_addr_o !== 32'h4 || inst_valid_o !== 1'b1) $display("FAIL hold_out: got %h@%h v%0b exp %h@00000004 v1", inst_o, inst_addr_o, inst_valid_o, mem(32'h4)); else n_pass++;
    n_total++; if (ibus_req_o !== 1'b0) $display("FAIL hold_noreq: got %0b exp 0", ibus_req_o); else n_pass++;
    cycle();
    n_total++; if (ibus_req_o !== 1'b0 || inst_addr_o !== 32'h4) $display("FAIL hold_still: req %0b addr %h exp 0/00000004", ibus_req_o, inst_addr_o); else n_pass++;
    hold_i = 1'b0;
    cycle();
    n_total++; if (inst_o !== mem(32'h8) || inst_addr_o !== 32'h8 || inst_valid_o !== 1'b1) $display("FAIL skid_out: got %h@%h v%0b exp %h@00000008 v1", inst_o, inst_addr_o, inst_valid_o, mem(32'h8)); else n_pass++;
    n_total++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'hC) $display("FAIL skid_nextreq: got %0b/%h exp 1/0000000c", ibus_req_o, ibus_addr_o); else n_pass++;
  endtask

  task automatic test_jump_wait();
    do_reset();
    cycle();
    cycle();   // 0x0 delivered
    hold_i = 1'b1;
    cycle();   // grant for 0x4, output held
    jump_i = 1'b1; jump_addr_i = 32'h0000_0103; rv_en = 1'b0;
    cycle();
    n_total++; if (inst_valid_o !== 1'b0 || inst_o !== NOP) $display("FAIL jw_squash: got %h v%0b exp %h v0", inst_o, inst_valid_o, NOP); else n_pass++;
    n_total++; if (ibus_req_o !== 1'b0) $display("FAIL jw_noreq: got %0b exp 0", ibus_req_o); else n_pass++;
    jump_i = 1'b0; hold_i = 1'b0; rv_en = 1'b1;
    cycle();   // stale 0x4 response dropped
    n_total++; if (inst_valid_o !== 1'b0) $display("FAIL jw_drop: got %0b exp 0", inst_valid_o); else n_pass++;
    n_total++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h100) $display("FAIL jw_target: got %0b/%h exp 1/00000100", ibus_req_o, ibus_addr_o); else n_pass++;
    cycle();
    cycle();
    n_total++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h100 || inst_o !== 32'h0010_0193) $display("FAIL jw_fetch: got %h@%h v%0b exp 00100193@00000100 v1", inst_o, inst_addr_o, inst_valid_o); else n_pass++;
  endtask

  task automatic test_jump_gnt();
    do_reset();
    jump_i = 1'b1; jump_addr_i = 32'h0000_0200;
    cycle();   // grant for 0x0 in the same cycle as the jump
    jump_i = 1'b0;
    cycle();
    n_total++; if (inst_valid_o !== 1'b0) $display("FAIL jg_drop: got %0b exp 0", inst_valid_o); else n_pass++;
    n_total++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h200) $display("FAIL jg_target: got %0b/%h exp 1/00000200", ibus_req_o, ibus_addr_o); else n_pass++;
    cycle();
    cycle();
    n_total++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h200 || inst_o !== 32'h0010_0293) $display("FAIL jg_fetch: got %h@%h v%0b exp 00100293@00000200 v1", inst_o, inst_addr_o, inst_valid_o); else n_pass++;
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    auto_gnt = 1'b0; jump_i = 1'b1; jump_addr_i = 32'hFFFF_FFFF;
    cycle();
    jump_i = 1'b0; auto_gnt = 1'b1;
    n_total++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'hFFFF_FFFC) $display("FAIL wrap_mask: got %0b/%h exp 1/fffffffc", ibus_req_o, ibus_addr_o); else n_pass++;
    cycle();
    cycle();
    n_total++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'hFFFF_FFFC || inst_o !== 32'hFFEF_FF6F) $display("FAIL wrap_fetch: got %h@%h v%0b exp ffefff6f@fffffffc v1", inst_o, inst_addr_o, inst_valid_o); else n_pass++;
    n_total++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0) $display("FAIL wrap_next: got %0b/%h exp 1/00000000", ibus_req_o, ibus_addr_o); else n_pass++;
    cycle();   // grant for 0x0, now waiting
    rst = 1'b1; rv_en = 1'b0;
    cycle();
    n_total++; if (ibus_req_o !== 1'b0) $display("FAIL midrst_req: got %0b exp 0", ibus_req_o); else n_pass++;
    rst = 1'b0; rv_en = 1'b1; auto_gnt = 1'b0;
    cycle();   // late response for the aborted fetch
    n_total++; if (inst_valid_o !== 1'b0 || inst_o !== NOP) $display("FAIL midrst_late: got %h v%0b exp %h v0", inst_o, inst_valid_o, NOP); else n_pass++;
    n_total++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0) $display("FAIL midrst_req_after: got %0b/%h exp 1/00000000", ibus_req_o, ibus_addr_o); else n_pass++;
    pend = 1'b0;
  endtask

  // Test sequence and summary.
  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1; jump_i = 1'b0; jump_addr_i = 32'h0; hold_i = 1'b0;
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = 32'h0;
    auto_gnt = 1'b1; rv_en = 1'b1; pend = 1'b0; pend_addr = 32'h0;
    test_reset();
    test_first_fetch();
    test_stream();
    test_hold_skid();
    test_jump_wait();
    test_jump_gnt();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
